// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: runs one SPI flash transaction (opcode, optional
// 24-bit address, 0..256 read bytes) over the SPI slave's register port.
// Ports: clk/rst_n; start_i/cmd_i/addr_i/addr_en_i/len_i/div_i/abort_i request;
// busy_o/done_o/err_o status; rd_data_o/rd_valid_o/rd_ready_i read stream;
// spi_* register-port master (write, read, irq).
module spi_flash_rd_seq #(
    parameter int unsigned TMO_W    = 16,
    parameter logic [7:0]  DUMMY_TX = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  cmd_i,
    input  logic [23:0] addr_i,
    input  logic        addr_en_i,
    input  logic [8:0]  len_i,
    input  logic [7:0]  div_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [7:0]  spi_waddr_o,
    output logic [31:0] spi_wdata_o,
    output logic [3:0]  spi_sel_o,
    output logic        spi_we_o,
    output logic [7:0]  spi_raddr_o,
    output logic        spi_rd_o,
    input  logic [31:0] spi_rdata_i,
    input  logic        spi_irq_i
);

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_DATA = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_LOAD, S_KICK, S_WAIT, S_SETTLE,
        S_RD, S_CAP, S_PUSH, S_DESEL, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, div_q, byte_q;
    logic [23:0]       addr_q;
    logic              addr_en_q;
    logic [8:0]        k_q, n_q;
    logic [TMO_W-1:0]  wdog_q;
    logic              err_q;

    logic [TMO_W-1:0]  wdog_nxt;
    logic [8:0]        k_nxt, hdr;
    logic              more, rd_phase;
    logic [7:0]        tx_byte;
    logic              accept, k_inc, wdog_run, tmo, cap;
    logic              rdata_unused;

    assign rdata_unused = ^spi_rdata_i[31:8];

    assign wdog_nxt = wdog_q + TMO_W'(1);
    assign k_nxt    = k_q + 9'd1;
    assign more     = (k_nxt < n_q);
    // Bytes before index hdr are opcode/address; the rest are reads.
    assign hdr      = addr_en_q ? 9'd4 : 9'd1;
    assign rd_phase = (k_q >= hdr);

    always_comb begin
        tx_byte = DUMMY_TX;
        unique case (1'b1)
            (k_q == 9'd0):              tx_byte = cmd_q;
            (addr_en_q && k_q == 9'd1): tx_byte = addr_q[23:16];
            (addr_en_q && k_q == 9'd2): tx_byte = addr_q[15:8];
            (addr_en_q && k_q == 9'd3): tx_byte = addr_q[7:0];
            default:                    tx_byte = DUMMY_TX;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        spi_waddr_o = '0;
        spi_wdata_o = '0;
        spi_sel_o   = '0;
        spi_we_o    = 1'b0;
        spi_raddr_o = '0;
        spi_rd_o    = 1'b0;
        accept      = 1'b0;
        k_inc       = 1'b0;
        wdog_run    = 1'b0;
        tmo         = 1'b0;
        cap         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = A_CTRL;
                spi_sel_o   = 4'b0011;
                spi_wdata_o = {16'h0, div_q, 8'b000_11000};
                state_d     = S_LOAD;
            end
            S_LOAD: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = A_DATA;
                spi_sel_o   = 4'b0001;
                spi_wdata_o = {24'h0, tx_byte};
                state_d     = S_KICK;
            end
            S_KICK: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = A_CTRL;
                spi_sel_o   = 4'b0011;
                spi_wdata_o = {16'h0, div_q, 8'b000_11001};
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (spi_irq_i) begin
                    state_d = S_SETTLE;
                end else if (&wdog_nxt) begin
                    // Counter would hit all-ones: give up on this byte.
                    tmo     = 1'b1;
                    state_d = S_DESEL;
                end else begin
                    wdog_run = 1'b1;
                end
            end
            S_SETTLE: state_d = S_RD;
            S_RD: begin
                spi_rd_o    = 1'b1;
                spi_raddr_o = A_DATA;
                state_d     = S_CAP;
            end
            S_CAP: begin
                cap = 1'b1;
                if (rd_phase) begin
                    state_d = S_PUSH;
                end else begin
                    k_inc   = 1'b1;
                    state_d = (more && !abort_i) ? S_LOAD : S_DESEL;
                end
            end
            S_PUSH: begin
                if (rd_ready_i) begin
                    k_inc   = 1'b1;
                    state_d = (more && !abort_i) ? S_LOAD : S_DESEL;
                end
            end
            S_DESEL: begin
                spi_we_o    = 1'b1;
                spi_waddr_o = A_CTRL;
                spi_sel_o   = 4'b0011;
                spi_wdata_o = {16'h0, div_q, 8'h00};
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            div_q     <= '0;
            addr_q    <= '0;
            addr_en_q <= 1'b0;
            n_q       <= '0;
            k_q       <= '0;
            wdog_q    <= '0;
            byte_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q     <= cmd_i;
                div_q     <= div_i;
                addr_q    <= addr_i;
                addr_en_q <= addr_en_i;
                n_q       <= 9'd1 + (addr_en_i ? 9'd3 : 9'd0) + len_i;
                k_q       <= '0;
                err_q     <= 1'b0;
            end
            if (k_inc) k_q <= k_nxt;
            if (state_q == S_KICK) begin
                wdog_q <= '0;
            end else if (wdog_run) begin
                wdog_q <= wdog_nxt;
            end
            if (tmo) err_q <= 1'b1;
            if (cap) byte_q <= spi_rdata_i[7:0];
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign rd_valid_o = (state_q == S_PUSH);
    assign rd_data_o  = byte_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb_spi_flash_rd_seq: directed bench for spi_flash_rd_seq with a
// behavioural SPI register slave (go -> irq after a few cycles).
module tb_spi_flash_rd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  cmd_i = '0;
    logic [23:0] addr_i = '0;
    logic        addr_en_i = 1'b0;
    logic [8:0]  len_i = '0;
    logic [7:0]  div_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b1;
    logic [7:0]  spi_waddr_o;
    logic [31:0] spi_wdata_o;
    logic [3:0]  spi_sel_o;
    logic        spi_we_o;
    logic [7:0]  spi_raddr_o;
    logic        spi_rd_o;
    logic [31:0] spi_rdata_i;
    logic        spi_irq_i;

    spi_flash_rd_seq #(.TMO_W(4), .DUMMY_TX(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .cmd_i(cmd_i),
        .addr_i(addr_i), .addr_en_i(addr_en_i), .len_i(len_i),
        .div_i(div_i), .abort_i(abort_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .spi_waddr_o(spi_waddr_o), .spi_wdata_o(spi_wdata_o),
        .spi_sel_o(spi_sel_o), .spi_we_o(spi_we_o),
        .spi_raddr_o(spi_raddr_o), .spi_rd_o(spi_rd_o),
        .spi_rdata_i(spi_rdata_i), .spi_irq_i(spi_irq_i)
    );

    always #5 clk = ~clk;

    // Slave model
    logic [7:0] rsp [0:15];
    logic       irq_off = 1'b0;
    logic       slave_clr = 1'b0;
    logic [1:0] irq_cnt;
    logic [3:0] xfer;
    logic [7:0] data_reg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_irq_i   <= 1'b0;
            spi_rdata_i <= '0;
            irq_cnt     <= '0;
            xfer        <= '0;
            data_reg    <= '0;
        end else begin
            spi_irq_i <= 1'b0;
            if (slave_clr) xfer <= '0;
            if (spi_rd_o) spi_rdata_i <= {24'h0, data_reg};
            if (spi_we_o && spi_waddr_o == 8'h00 && spi_wdata_o[0]) begin
                irq_cnt <= 2'd3;
            end else if (irq_cnt != 2'd0) begin
                irq_cnt <= irq_cnt - 2'd1;
                if (irq_cnt == 2'd1 && !irq_off) begin
                    spi_irq_i <= 1'b1;
                    data_reg  <= rsp[xfer];
                    xfer      <= xfer + 4'd1;
                end
            end
        end
    end

    // Monitor
    int          cyc = 0;
    int          done_cnt = 0;
    int          excl_bad = 0;
    logic [7:0]  w_addr [$];
    logic [31:0] w_data [$];
    int          w_cyc  [$];
    logic [7:0]  mosi   [$];
    logic [7:0]  rdq    [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spi_we_o) begin
            w_addr.push_back(spi_waddr_o);
            w_data.push_back(spi_wdata_o);
            w_cyc.push_back(cyc);
            if (spi_waddr_o == 8'h04) mosi.push_back(spi_wdata_o[7:0]);
        end
        if (spi_we_o && spi_rd_o) excl_bad <= excl_bad + 1;
        if (rd_valid_o && rd_ready_i) rdq.push_back(rd_data_o);
        if (done_o) done_cnt <= done_cnt + 1;
    end

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [7:0] c, input logic [23:0] a,
                             input logic ae, input logic [8:0] l);
        @(negedge clk);
        cmd_i = c; addr_i = a; addr_en_i = ae; len_i = l;
        div_i = 8'h04; start_i = 1'b1; slave_clr = 1'b1;
        @(negedge clk);
        start_i = 1'b0; slave_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done"}, {31'd0, done_o}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rd_valid_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, {31'd0, rd_valid_o}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int wb, mb, rb, db, bad, n;
        logic [7:0] e1 [0:5];
        e1[0] = 8'h03; e1[1] = 8'h12; e1[2] = 8'h34;
        e1[3] = 8'h56; e1[4] = 8'h00; e1[5] = 8'h00;
        for (int i = 0; i < 16; i++) rsp[i] = 8'h00;

        // Reset
        repeat (3) @(negedge clk);
        chk("reset outs",
            {26'd0, busy_o, done_o, err_o, rd_valid_o, spi_we_o, spi_rd_o},
            32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: read 2 bytes with address
        rsp[4] = 8'hA5; rsp[5] = 8'h5A;
        wb = w_data.size(); mb = mosi.size(); rb = rdq.size(); db = done_cnt;
        start_txn(8'h03, 24'h123456, 1'b1, 9'd2);
        chk("t1 busy", {31'd0, busy_o}, 32'd1);
        wait_done("t1");
        chk("t1 mosi n", mosi.size() - mb, 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1 mosi%0d", i), {24'd0, mosi[mb+i]}, {24'd0, e1[i]});
        chk("t1 rd n", rdq.size() - rb, 32'd2);
        chk("t1 rd0", {24'd0, rdq[rb]}, 32'hA5);
        chk("t1 rd1", {24'd0, rdq[rb+1]}, 32'h5A);
        chk("t1 w n", w_data.size() - wb, 32'd14);
        chk("t1 cfg", w_data[wb], 32'h0000_0418);
        chk("t1 kick", w_data[wb+2], 32'h0000_0419);
        chk("t1 desel", w_data[wb+13], 32'h0000_0400);
        chk("t1 desel a", {24'd0, w_addr[wb+13]}, 32'h0);
        chk("t1 done n", done_cnt - db, 32'd1);
        chk("t1 err", {31'd0, err_o}, 32'd0);
        chk("t1 idle", {31'd0, busy_o}, 32'd0);

        // 2: command only
        wb = w_data.size(); rb = rdq.size(); db = done_cnt;
        start_txn(8'h06, 24'h0, 1'b0, 9'd0);
        wait_done("t2");
        chk("t2 w n", w_data.size() - wb, 32'd4);
        chk("t2 w0", w_data[wb], 32'h0000_0418);
        chk("t2 w1", w_data[wb+1], 32'h0000_0006);
        chk("t2 w1 a", {24'd0, w_addr[wb+1]}, 32'h04);
        chk("t2 w2", w_data[wb+2], 32'h0000_0419);
        chk("t2 w3", w_data[wb+3], 32'h0000_0400);
        chk("t2 rd n", rdq.size() - rb, 32'd0);
        chk("t2 done n", done_cnt - db, 32'd1);

        // 3: backpressure on byte 2 of 3
        rsp[1] = 8'h11; rsp[2] = 8'h22; rsp[3] = 8'h33;
        rb = rdq.size();
        rd_ready_i = 1'b0;
        start_txn(8'h0B, 24'h0, 1'b0, 9'd3);
        wait_valid("t3 b1");
        chk("t3 b1 data", {24'd0, rd_data_o}, 32'h11);
        rd_ready_i = 1'b1;
        @(negedge clk);
        rd_ready_i = 1'b0;
        wait_valid("t3 b2");
        mb = mosi.size();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rd_valid_o || rd_data_o !== 8'h22) bad++;
        end
        chk("t3 stable", bad, 32'd0);
        chk("t3 no load", mosi.size() - mb, 32'd0);
        rd_ready_i = 1'b1;
        wait_done("t3");
        chk("t3 rd n", rdq.size() - rb, 32'd3);
        chk("t3 rd0", {24'd0, rdq[rb]}, 32'h11);
        chk("t3 rd1", {24'd0, rdq[rb+1]}, 32'h22);
        chk("t3 rd2", {24'd0, rdq[rb+2]}, 32'h33);

        // 4: watchdog timeout
        irq_off = 1'b1;
        wb = w_data.size(); db = done_cnt;
        start_txn(8'h05, 24'h0, 1'b0, 9'd0);
        wait_done("t4");
        chk("t4 w n", w_data.size() - wb, 32'd4);
        chk("t4 wait cyc", w_cyc[wb+3] - w_cyc[wb+2], 32'd16);
        chk("t4 desel", w_data[wb+3], 32'h0000_0400);
        chk("t4 err", {31'd0, err_o}, 32'd1);
        chk("t4 done n", done_cnt - db, 32'd1);
        irq_off = 1'b0;

        // 5: abort during first read byte of 8
        for (int i = 1; i < 9; i++) rsp[i] = 8'hC0 + 8'(i);
        mb = mosi.size(); rb = rdq.size(); db = done_cnt; wb = w_data.size();
        start_txn(8'h03, 24'h0, 1'b0, 9'd8);
        chk("t5 err clr", {31'd0, err_o}, 32'd0);
        n = 0;
        while (mosi.size() - mb < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5 load1", mosi.size() - mb, 32'd2);
        abort_i = 1'b1;
        wait_done("t5");
        abort_i = 1'b0;
        chk("t5 rd n", rdq.size() - rb, 32'd1);
        chk("t5 rd0", {24'd0, rdq[rb]}, 32'hC1);
        chk("t5 mosi n", mosi.size() - mb, 32'd2);
        chk("t5 last w", w_data[w_data.size()-1], 32'h0000_0400);
        chk("t5 done n", done_cnt - db, 32'd1);
        chk("t5 err", {31'd0, err_o}, 32'd0);

        // 6: reset while waiting for irq
        irq_off = 1'b1;
        wb = w_data.size(); db = done_cnt;
        start_txn(8'h03, 24'h0, 1'b0, 9'd1);
        n = 0;
        while (w_data.size() - wb < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t6 kicked", w_data.size() - wb, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6 rst outs",
            {busy_o, done_o, err_o, rd_valid_o, rd_data_o, spi_we_o,
             spi_rd_o, spi_waddr_o, spi_sel_o, spi_raddr_o}, 32'd0);
        chk("t6 rst wdata", spi_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        irq_off = 1'b0;
        chk("t6 no done", done_cnt - db, 32'd0);
        rsp[4] = 8'h9E;
        mb = mosi.size(); rb = rdq.size(); db = done_cnt;
        start_txn(8'h03, 24'hAABBCC, 1'b1, 9'd1);
        wait_done("t6");
        chk("t6 mosi n", mosi.size() - mb, 32'd5);
        chk("t6 mosi1", {24'd0, mosi[mb+1]}, 32'hAA);
        chk("t6 mosi3", {24'd0, mosi[mb+3]}, 32'hCC);
        chk("t6 rd n", rdq.size() - rb, 32'd1);
        chk("t6 rd0", {24'd0, rdq[rb]}, 32'h9E);
        chk("t6 done n", done_cnt - db, 32'd1);

        chk("strobe excl", excl_bad, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_flash_rd_seq.md
Name: spi_flash_rd_seq

Overview:
Bus-master sequencer that drives the SPI peripheral's register port to run one complete SPI transaction without CPU polling. A transaction is an opcode, an optional 24-bit address and 0–256 read bytes; read bytes are streamed out on a valid/ready interface.
It sits between a requester (boot loader or DMA) and the SPI register slave, and owns that slave's bus port while busy. It uses the peripheral's end-of-transfer interrupt for byte completion.

Parameters:
TMO_W, 16, width of the per-byte watchdog counter; timeout after 2^TMO_W-1 cycles waiting for irq.
DUMMY_TX, 8'h00, byte shifted out on MOSI during the read phase.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle request pulse; ignored while busy_o=1
cmd_i  in  8  opcode byte
addr_i  in  24  flash address, sent MSB byte first
addr_en_i  in  1  1 = send the 3 address bytes after the opcode
len_i  in  9  read byte count, 0..256; 0 = command-only transaction
div_i  in  8  SPI clk div value written to CTRL[15:8]
abort_i  in  1  terminate the transaction at the next byte boundary
busy_o  out  1  transaction in progress
done_o  out  1  one-cycle pulse at end of transaction
err_o  out  1  sticky timeout flag; cleared by the next accepted start_i
rd_data_o  out  8  read byte
rd_valid_o  out  1  rd_data_o valid
rd_ready_i  in  1  consumer ready
spi_waddr_o  out  8  slave write offset
spi_wdata_o  out  32  slave write data
spi_sel_o  out  4  slave byte enables
spi_we_o  out  1  slave write strobe
spi_raddr_o  out  8  slave read offset
spi_rd_o  out  1  slave read strobe
spi_rdata_i  in  32  slave read data; valid 1 cycle after spi_rd_o
spi_irq_i  in  1  slave end-of-transfer interrupt pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-transaction abandons the transaction with no done_o. CS is released through the slave's own reset.
- Slave register map: CTRL 0x00, DATA 0x04, STATUS 0x08.
- CTRL fields: [0] go, [1] CPOL, [2] CPHA, [3] CS, [4] irq enable, [15:8] div. This block always writes CPOL=CPHA=0.
- IDLE: on start_i, latch cmd, addr, addr_en, len and div; clear err_o; set busy_o. Byte total N = 1 + 3*addr_en + len. Go to CFG.
- CFG: write CTRL, sel=4'b0011, data={div,8'b000_11000} (CS=1, irq en=1, go=0). Go to LOAD.
- LOAD: write DATA, sel=4'b0001. Data byte by index k: k=0 cmd; k=1..3 addr[23:16], addr[15:8], addr[7:0] when addr_en; otherwise DUMMY_TX. Go to KICK.
- KICK: write CTRL with go=1, data={div,8'b000_11001}. Go to WAIT.
- WAIT: spi_we_o=0 so the slave self-clears go; watchdog counts.
  - spi_irq_i=1 → SETTLE.
  - Watchdog reaches all-ones → set err_o, go to DESEL.
- SETTLE: one idle cycle so the slave's DATA register updates. Go to RD.
- RD: spi_rd_o=1, raddr=0x04 for one cycle. Next cycle, CAP captures spi_rdata_i[7:0].
- CAP:
  - k is in the read phase (k >= N-len) → PUSH.
  - Otherwise k++, then LOAD if k<N, else DESEL.
- PUSH: rd_valid_o=1 holding the captured byte until rd_ready_i=1. Valid and data stay stable under backpressure. Transfer cycle: k++, then LOAD or DESEL.
- abort_i: sampled in CAP, or on the PUSH transfer cycle. If high, go to DESEL instead of LOAD; no error.
- DESEL: write CTRL data={div,8'h00} (CS=0, irq off). Go to DONE.
- DONE: done_o=1 for one cycle, busy_o=0 next cycle, return to IDLE.
- start_i in the same cycle as done_o is ignored.
- Strobes are mutually exclusive: at most one of spi_we_o / spi_rd_o is high per cycle. Unused write-data bits are 0.
- Watchdog is reset on entering WAIT.

Test Plan:
- cmd=0x03, addr=0x123456, addr_en=1, len=2, slave model returns 0xA5,0x5A, rd_ready=1 → MOSI bytes 03 12 34 56 00 00; rd stream A5, 5A; one done_o; err_o=0.
- cmd=0x06, addr_en=0, len=0 → writes: CTRL, DATA=06, CTRL go, then CTRL=0x00 after irq; no rd_valid_o; done_o once.
- len=3 with rd_ready_i held low 20 cycles on byte 2 → rd_valid_o/rd_data_o stable; no further DATA write until the handshake; all 3 bytes delivered in order.
- Slave irq suppressed, TMO_W=4 → err_o=1 after 15 WAIT cycles; CTRL=0x00 written; done_o pulses; next start_i clears err_o.
- abort_i pulsed during byte 1 of len=8 → DESEL after that byte; only bytes up to and including the current one are streamed; done_o=1, err_o=0.
- rst_n asserted while in WAIT → all outputs 0 immediately; new start_i after release runs a normal transaction.
